// File: rtl/stream_writer_pkg.sv
// rtl/stream_writer_pkg.sv - shared types, completion error bit indices and keep helper
package stream_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        WAIT_DONE,
        CMPL
    } state_t;

    localparam int CMPL_ERR_WRITE = 0;
    localparam int CMPL_ERR_TRUNC = 1;
    localparam int CMPL_ERR_EMPTY = 2;

    // Widest supported keep (128-bit bus); narrower keeps are zero-extended.
    localparam int KEEP_MAX_W = 16;

    // Number of consecutive ones starting at bit 0.
    function automatic logic [4:0] ones_to_len(input logic [KEEP_MAX_W-1:0] keep);
        logic [4:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            if (run && keep[i]) begin
                n = n + 5'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/keep_to_bytes.sv
// rtl/keep_to_bytes.sv - byte count of a beat from its LSB-contiguous keep mask
module keep_to_bytes
    import stream_writer_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    localparam int KEEP_W     = DATA_WIDTH / 8,
    localparam int CNT_W      = $clog2(KEEP_W) + 1
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  beat_bytes
);

    logic [KEEP_MAX_W-1:0] keep_ext;
    logic [4:0]            len_full;

    assign keep_ext   = KEEP_MAX_W'(keep);
    assign len_full   = ones_to_len(keep_ext);
    assign beat_bytes = CNT_W'(len_full);

endmodule

// File: rtl/stream_to_fifo_writer.sv
// rtl/stream_to_fifo_writer.sv - store-and-forward frame buffering ahead of the FIFO-to-AXI write engine
module stream_to_fifo_writer
    import stream_writer_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_FRAME_BYTES = 2048
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    desc_valid,
    input  logic [ADDR_WIDTH-1:0]   desc_addr,
    output logic                    desc_ready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic                    fifo_wr_en,
    output logic [DATA_WIDTH-1:0]   fifo_wr_data,
    input  logic                    fifo_full,
    output logic                    mem_w_start,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [LEN_WIDTH-1:0]    mem_w_len,
    input  logic                    mem_w_busy,
    input  logic                    mem_w_done,
    input  logic                    mem_w_error,
    output logic                    cmpl_valid,
    output logic [ADDR_WIDTH-1:0]   cmpl_addr,
    output logic [LEN_WIDTH-1:0]    cmpl_len,
    output logic [2:0]              cmpl_error,
    input  logic                    cmpl_ready
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(KEEP_W) + 1;
    localparam logic [LEN_WIDTH:0] MAX_CNT   = (LEN_WIDTH + 1)'(MAX_FRAME_BYTES);
    localparam logic [LEN_WIDTH:0] FULL_BEAT = (LEN_WIDTH + 1)'(KEEP_W);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH:0]      byte_cnt_q, byte_cnt_d;
    logic                    trunc_q, trunc_d;
    logic                    wr_err_q, wr_err_d;
    logic                    empty_q, empty_d;
    logic                    mem_w_start_q, mem_w_start_d;
    logic [CNT_W-1:0]        keep_bytes;
    logic [LEN_WIDTH:0]      beat_bytes;
    logic                    beat_hs;
    logic                    unused_busy;

    keep_to_bytes #(.DATA_WIDTH(DATA_WIDTH)) u_keep_to_bytes (
        .keep       (s_tkeep),
        .beat_bytes (keep_bytes)
    );

    // Only the final beat may be partial; earlier beats count as full words.
    assign beat_bytes  = s_tlast ? (LEN_WIDTH + 1)'(keep_bytes) : FULL_BEAT;
    assign unused_busy = mem_w_busy;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        byte_cnt_d    = byte_cnt_q;
        trunc_d       = trunc_q;
        wr_err_d      = wr_err_q;
        empty_d       = empty_q;
        mem_w_start_d = 1'b0;
        desc_ready    = 1'b0;
        s_tready      = 1'b0;
        fifo_wr_en    = 1'b0;
        cmpl_valid    = 1'b0;
        beat_hs       = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    desc_ready = 1'b1;
                    if (desc_valid) begin
                        addr_d     = desc_addr;
                        byte_cnt_d = '0;
                        trunc_d    = 1'b0;
                        wr_err_d   = 1'b0;
                        empty_d    = 1'b0;
                        state_d    = RECV;
                    end
                end
                RECV: begin
                    s_tready = !fifo_full;
                    beat_hs  = s_tvalid && s_tready;
                    if (beat_hs) begin
                        // Past the limit beats are still accepted so the frame drains to tlast.
                        if (byte_cnt_q < MAX_CNT) begin
                            if (beat_bytes != '0) begin
                                fifo_wr_en = 1'b1;
                                byte_cnt_d = byte_cnt_q + beat_bytes;
                            end
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (s_tlast) begin
                            if (byte_cnt_d == '0) begin
                                empty_d = 1'b1;
                                state_d = CMPL;
                            end else begin
                                mem_w_start_d = 1'b1;
                                state_d       = START;
                            end
                        end
                    end
                end
                START: begin
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mem_w_done) begin
                        wr_err_d = mem_w_error;
                        state_d  = CMPL;
                    end
                end
                CMPL: begin
                    cmpl_valid = 1'b1;
                    if (cmpl_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            byte_cnt_q    <= '0;
            trunc_q       <= 1'b0;
            wr_err_q      <= 1'b0;
            empty_q       <= 1'b0;
            mem_w_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            byte_cnt_q    <= byte_cnt_d;
            trunc_q       <= trunc_d;
            wr_err_q      <= wr_err_d;
            empty_q       <= empty_d;
            mem_w_start_q <= mem_w_start_d;
        end
    end

    always_comb begin
        cmpl_error                 = '0;
        cmpl_error[CMPL_ERR_WRITE] = wr_err_q;
        cmpl_error[CMPL_ERR_TRUNC] = trunc_q;
        cmpl_error[CMPL_ERR_EMPTY] = empty_q;
    end

    assign fifo_wr_data = s_tdata;
    assign mem_w_start  = mem_w_start_q;
    assign mem_w_addr   = addr_q;
    assign mem_w_len    = byte_cnt_q[LEN_WIDTH-1:0];
    assign cmpl_addr    = addr_q;
    assign cmpl_len     = byte_cnt_q[LEN_WIDTH-1:0];

endmodule

// File: tb/tb_stream_to_fifo_writer.sv
// tb/tb_stream_to_fifo_writer.sv - self-checking bench for stream_to_fifo_writer
module tb_stream_to_fifo_writer;

    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int LW   = 16;
    localparam int MAXB = 2048;
    localparam int KW   = DW / 8;

    logic          clock;
    logic          resetn;
    logic          desc_valid;
    logic [AW-1:0] desc_addr;
    logic          desc_ready;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full;
    logic          mem_w_start;
    logic [AW-1:0] mem_w_addr;
    logic [LW-1:0] mem_w_len;
    logic          mem_w_busy;
    logic          mem_w_done;
    logic          mem_w_error;
    logic          cmpl_valid;
    logic [AW-1:0] cmpl_addr;
    logic [LW-1:0] cmpl_len;
    logic [2:0]    cmpl_error;
    logic          cmpl_ready;

    int checks = 0;
    int errors = 0;

    stream_to_fifo_writer #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .LEN_WIDTH       (LW),
        .MAX_FRAME_BYTES (MAXB)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .desc_valid   (desc_valid),
        .desc_addr    (desc_addr),
        .desc_ready   (desc_ready),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .mem_w_start  (mem_w_start),
        .mem_w_addr   (mem_w_addr),
        .mem_w_len    (mem_w_len),
        .mem_w_busy   (mem_w_busy),
        .mem_w_done   (mem_w_done),
        .mem_w_error  (mem_w_error),
        .cmpl_valid   (cmpl_valid),
        .cmpl_addr    (cmpl_addr),
        .cmpl_len     (cmpl_len),
        .cmpl_error   (cmpl_error),
        .cmpl_ready   (cmpl_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        int            nbeats;
        logic [KW-1:0] last_keep;
        int            full_at;
        int            full_len;
        logic          werr;
        int            hold;
        int            exp_len;
        logic [2:0]    exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame outcome from the rules: all but the last beat are full words, the limit caps the
    // word count, and any beat arriving once the limit is reached marks truncation.
    function automatic void model_frame(input int nbeats, input logic [KW-1:0] last_keep,
                                        output int len, output logic [2:0] err, output int pushes);
        int lb;
        int cap;
        int f;
        lb = 0;
        while (lb < KW && last_keep[lb]) lb++;
        cap = MAXB / KW;
        f   = nbeats - 1;
        if (f >= cap) begin
            len    = MAXB;
            err    = 3'b010;
            pushes = cap;
        end else begin
            len    = KW * f + lb;
            err    = (len == 0) ? 3'b100 : 3'b000;
            pushes = f + ((lb != 0) ? 1 : 0);
        end
    endfunction

    task automatic check_cmpl(input vec_t v);
        chk("cmpl_valid", cmpl_valid, 1);
        chk("cmpl_addr", cmpl_addr, v.addr);
        chk("cmpl_len", cmpl_len, v.exp_len);
        chk("cmpl_error", cmpl_error, v.exp_err);
        chk("desc_ready_in_cmpl", desc_ready, 0);
    endtask

    task automatic run_frame(input vec_t v, input bit gaps);
        int            mlen;
        logic [2:0]    merr;
        int            exp_pushes;
        int            pushes;
        int            idx;
        int            cyc;
        int            budget;
        logic [DW-1:0] data;
        model_frame(v.nbeats, v.last_keep, mlen, merr, exp_pushes);
        pushes = 0;
        idx    = 0;
        cyc    = 0;
        budget = v.nbeats * 4 + 40;
        @(negedge clock);
        desc_valid = 1'b1;
        desc_addr  = v.addr;
        #1;
        chk("desc_ready_idle", desc_ready, 1);
        data = {$urandom, $urandom};
        while (idx < v.nbeats && cyc < budget) begin
            @(negedge clock);
            desc_valid = 1'b0;
            desc_addr  = $urandom;
            fifo_full  = (cyc >= v.full_at) && (cyc < v.full_at + v.full_len);
            s_tvalid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata    = data;
            s_tlast    = (idx == v.nbeats - 1);
            s_tkeep    = s_tlast ? v.last_keep : KW'($urandom);
            #1;
            if (fifo_full) begin
                chk("s_tready_while_full", s_tready, 0);
                chk("fifo_wr_en_while_full", fifo_wr_en, 0);
            end else begin
                chk("s_tready_recv", s_tready, 1);
            end
            if (fifo_wr_en) begin
                pushes++;
                chk("fifo_wr_data", fifo_wr_data, data);
            end
            if (s_tvalid && s_tready) begin
                idx++;
                data = {$urandom, $urandom};
            end
            cyc++;
        end
        if (idx < v.nbeats) chk("beat_timeout", idx, v.nbeats);
        chk("push_count", pushes, exp_pushes);
        @(negedge clock);
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        fifo_full = 1'b0;
        #1;
        if (v.exp_len != 0) begin
            chk("mem_w_start", mem_w_start, 1);
            chk("mem_w_addr", mem_w_addr, v.addr);
            chk("mem_w_len", mem_w_len, v.exp_len);
            chk("cmpl_valid_before_done", cmpl_valid, 0);
            mem_w_busy = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clock);
                #1;
                chk("mem_w_start_one_cycle", mem_w_start, 0);
                chk("cmpl_valid_waiting", cmpl_valid, 0);
            end
            @(negedge clock);
            mem_w_done  = 1'b1;
            mem_w_error = v.werr;
            @(negedge clock);
            mem_w_done  = 1'b0;
            mem_w_error = 1'b0;
            mem_w_busy  = 1'b0;
            #1;
        end else begin
            chk("mem_w_start_empty", mem_w_start, 0);
        end
        repeat (v.hold) begin
            check_cmpl(v);
            if (v.exp_len != 0) chk("mem_w_len_held", mem_w_len, v.exp_len);
            @(negedge clock);
            #1;
        end
        cmpl_ready = 1'b1;
        check_cmpl(v);
        @(negedge clock);
        cmpl_ready = 1'b0;
        #1;
        chk("cmpl_valid_after_hs", cmpl_valid, 0);
        chk("desc_ready_after_hs", desc_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       rv;
        int         mlen;
        logic [2:0] merr;
        int         mp;
        int         r;

        vecs[0] = '{32'h1000, 3,   8'h0F, 0, 0, 1'b0, 0, 20,   3'b000};
        vecs[1] = '{32'h2000, 260, 8'hFF, 0, 0, 1'b0, 0, 2048, 3'b010};
        vecs[2] = '{32'h3000, 1,   8'h00, 0, 0, 1'b0, 0, 0,    3'b100};
        vecs[3] = '{32'h4000, 6,   8'hFF, 2, 5, 1'b0, 1, 48,   3'b000};
        vecs[4] = '{32'h5000, 2,   8'h07, 0, 0, 1'b1, 4, 11,   3'b001};
        vecs[5] = '{32'h6000, 256, 8'h3F, 0, 0, 1'b0, 0, 2046, 3'b000};
        vecs[6] = '{32'h7000, 257, 8'h00, 0, 0, 1'b0, 0, 2048, 3'b010};
        vecs[7] = '{32'h8000, 2,   8'h00, 0, 0, 1'b0, 0, 8,    3'b000};
        vecs[8] = '{32'h9000, 1,   8'h0B, 0, 0, 1'b1, 2, 2,    3'b001};
        vecs[9] = '{32'hA000, 256, 8'hFF, 0, 0, 1'b0, 0, 2048, 3'b000};

        resetn      = 1'b0;
        desc_valid  = 1'b1;
        desc_addr   = '0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = 1'b0;
        s_tvalid    = 1'b1;
        fifo_full   = 1'b0;
        mem_w_busy  = 1'b0;
        mem_w_done  = 1'b0;
        mem_w_error = 1'b0;
        cmpl_ready  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_desc_ready", desc_ready, 0);
        chk("reset_s_tready", s_tready, 0);
        chk("reset_fifo_wr_en", fifo_wr_en, 0);
        @(negedge clock);
        resetn     = 1'b1;
        desc_valid = 1'b0;
        s_tvalid   = 1'b0;
        #1;
        chk("idle_desc_ready", desc_ready, 1);
        chk("idle_cmpl_valid", cmpl_valid, 0);
        chk("idle_mem_w_start", mem_w_start, 0);
        chk("idle_mem_w_len", mem_w_len, 0);
        chk("idle_s_tready", s_tready, 0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], 1'b0);

        // Reset asserted for one cycle in the middle of a frame.
        @(negedge clock);
        desc_valid = 1'b1;
        desc_addr  = 32'hB000;
        @(negedge clock);
        desc_valid = 1'b0;
        s_tvalid   = 1'b1;
        s_tkeep    = 8'hFF;
        s_tlast    = 1'b0;
        s_tdata    = 64'h1122334455667788;
        #1;
        chk("mid_frame_push", fifo_wr_en, 1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_desc_ready", desc_ready, 0);
        @(negedge clock);
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        #1;
        chk("post_rst_desc_ready", desc_ready, 1);
        chk("post_rst_mem_w_start", mem_w_start, 0);
        chk("post_rst_mem_w_len", mem_w_len, 0);
        chk("post_rst_cmpl_valid", cmpl_valid, 0);
        chk("post_rst_cmpl_error", cmpl_error, 0);
        chk("post_rst_s_tready", s_tready, 0);
        run_frame(vecs[0], 1'b0);

        for (int i = 0; i < 24; i++) begin
            rv.addr   = {$urandom_range(0, 65535), 16'h0000} | (AW'($urandom_range(0, 255)) << 3);
            rv.nbeats = ($urandom_range(0, 4) == 0) ? $urandom_range(254, 259) : $urandom_range(1, 10);
            r = $urandom_range(0, 9);
            rv.last_keep = (r <= 8) ? KW'((1 << r) - 1) : KW'($urandom);
            rv.full_at  = $urandom_range(0, rv.nbeats);
            rv.full_len = $urandom_range(0, 6);
            rv.werr     = 1'($urandom_range(0, 1));
            rv.hold     = $urandom_range(0, 3);
            model_frame(rv.nbeats, rv.last_keep, mlen, merr, mp);
            rv.exp_len = mlen;
            rv.exp_err = merr | ((mlen != 0) ? {2'b00, rv.werr} : 3'b000);
            run_frame(rv, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_to_fifo_writer.md
Name: stream_to_fifo_writer

Overview:
- Upstream feeder of the FIFO-to-AXI write engine.
- Accepts one descriptor (destination address) per frame and a byte-keyed data stream, and buffers the whole frame into the data FIFO (store-and-forward).
- After the frame's last beat, pulses the memory-write start with address and byte length. Waits for done, then issues a completion record.
- Guarantees the FIFO holds the full frame before the write engine begins reading, because that engine reads without checking for empty.

Parameters:
- DATA_WIDTH, 64, stream and FIFO word width in bits (32/64/128).
- ADDR_WIDTH, 32, memory address width.
- LEN_WIDTH, 16, byte length width of mem_w_len and cmpl_len.
- MAX_FRAME_BYTES, 2048, truncation limit; must be a multiple of DATA_WIDTH/8 and no larger than the FIFO depth in bytes.

Ports:
- clock  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- desc_valid  in  1  descriptor valid
- desc_addr  in  ADDR_WIDTH  destination address (bus-aligned)
- desc_ready  out  1  descriptor accept
- s_tdata  in  DATA_WIDTH  stream data
- s_tkeep  in  DATA_WIDTH/8  byte enables, contiguous from LSB
- s_tlast  in  1  last beat of frame
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- fifo_wr_en  out  1  FIFO push
- fifo_wr_data  out  DATA_WIDTH  FIFO data
- fifo_full  in  1  FIFO full
- mem_w_start  out  1  one-cycle write start pulse
- mem_w_addr  out  ADDR_WIDTH  write address
- mem_w_len  out  LEN_WIDTH  write length in bytes
- mem_w_busy  in  1  write engine busy
- mem_w_done  in  1  write complete pulse
- mem_w_error  in  1  error, valid with done
- cmpl_valid  out  1  completion valid
- cmpl_addr  out  ADDR_WIDTH  frame address
- cmpl_len  out  LEN_WIDTH  bytes written
- cmpl_error  out  3  [0] write error, [1] truncated, [2] empty frame
- cmpl_ready  in  1  completion accept

Behaviour:
- States: IDLE, RECV, START, WAIT_DONE, CMPL.
- Reset: state IDLE; mem_w_start, cmpl_valid, fifo_wr_en = 0; byte_cnt = 0; flags cleared. desc_ready and s_tready are 0 while resetn is low.
- Reset mid-frame: the FIFO is not flushed by this block; flushing is the system's responsibility.
- IDLE:
  - desc_ready = 1.
  - On desc_valid: latch desc_addr, clear byte_cnt and truncate/error flags, go to RECV.
- RECV:
  - s_tready = !fifo_full (combinational).
  - Beat handshake = s_tvalid && s_tready.
  - beat_bytes = count of leading ones in s_tkeep. Non-last beats always count DATA_WIDTH/8 bytes regardless of s_tkeep.
  - A beat is pushed (fifo_wr_en = 1, fifo_wr_data = s_tdata, same cycle, combinational) iff byte_cnt < MAX_FRAME_BYTES and beat_bytes != 0; on push, byte_cnt += beat_bytes.
  - A handshaked beat arriving with byte_cnt == MAX_FRAME_BYTES is discarded and sets the truncated flag. Accepting and discarding continue until tlast.
  - byte_cnt is LEN_WIDTH+1 bits wide; MAX_FRAME_BYTES < 2^LEN_WIDTH is required.
  - On the tlast handshake: if the final byte_cnt == 0, set empty and go to CMPL; else go to START.
- START:
  - Registered mem_w_start = 1 for exactly one cycle, appearing in the cycle after the tlast handshake.
  - mem_w_addr = latched addr; mem_w_len = byte_cnt. Both are held stable until the CMPL exit.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On mem_w_done: latch mem_w_error into cmpl_error[0]; go to CMPL.
  - mem_w_busy is informational only.
- CMPL:
  - cmpl_valid = 1 with addr, len = byte_cnt and error, held stable until cmpl_ready.
  - On handshake, go to IDLE.
  - desc_ready = 0, so there is no overlap between frames.
- Simultaneous events:
  - fifo_full is sampled combinationally, so no push is ever issued while full.
  - A tlast beat that is also a truncated beat sets truncated and exits RECV in the same cycle.

Decomposition:
- Package stream_writer_pkg contains:
  - the state_t enum;
  - CMPL_ERR_WRITE/TRUNC/EMPTY bit indices;
  - a function ones_to_len(keep) for the leading-ones count.
- Sub-module keep_to_bytes, combinational, parameterized by DATA_WIDTH: s_tkeep → beat byte count.
- Everything else is a single always_ff FSM plus datapath registers.

Test Plan:
- Frame sizes (DATA_WIDTH=64, MAX=2048):
  - desc 0x1000 plus a 3-beat frame with last tkeep=0x0F → 3 FIFO pushes; mem_w_start one cycle after tlast with len=20, addr=0x1000; done(error=0) → cmpl len=20, error=0.
  - 260 full beats → 256 pushes; len=2048; cmpl_error=3'b010.
  - Single beat with tkeep=0x00 and tlast → no push, no mem_w_start; cmpl len=0, error=3'b100.
- fifo_full asserted for 5 cycles mid-frame → s_tready=0 and fifo_wr_en=0 throughout; no beat lost; len correct afterwards.
- mem_w_done with mem_w_error=1; cmpl_ready held low 4 cycles → cmpl_valid and fields stable for 4 cycles; error=3'b001; desc_ready stays 0 until the handshake.
- resetn low for 1 cycle during RECV → next cycle state IDLE with all outputs at reset values; the following frame completes normally.
